uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter LW, default 4, level width, equal to log2(DEPTH)+1.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cfg_en  in  1  host enable for reception.
REQ-006 cfg_chk  in  1  parity-check enable, forwarded to the receiver.
REQ-007 cfg_hold  in  1  when 1, a parity error stops reception.
REQ-008 cfg_thr  in  LW  interrupt threshold level.
REQ-009 clr  in  1  one-cycle pulse; clears sticky flags and leaves the error-hold state.
REQ-010 rx_int  in  1  receiver byte-done flag; may stay high several cycles.
REQ-011 rx_dat  in  8  receiver data.
REQ-012 rx_err  in  1  receiver parity error.
REQ-013 rx_en  out  1  receiver enable.
REQ-014 rx_chk  out  1  receiver parity enable.
REQ-015 rd_req  in  1  host pop request.
REQ-016 rd_dat  out  8  popped data.
REQ-017 rd_perr  out  1  parity error of the popped byte.
REQ-018 rd_vld  out  1  one-cycle strobe; rd_dat and rd_perr are valid while it is high.
REQ-019 empty, full  out  1 each  FIFO status.
REQ-020 level  out  LW  FIFO occupancy, 0..DEPTH.
REQ-021 ovf  out  1  sticky overflow flag.
REQ-022 perr_cnt  out  8  count of bytes received with a parity error.
REQ-023 irq  out  1  level interrupt.

Function
REQ-024 States: OFF, RUN, EHOLD; 2-bit state register.
REQ-025 OFF->RUN when cfg_en=1; RUN->OFF when cfg_en=0; RUN->EHOLD on a push with rx_err=1 and cfg_hold=1; EHOLD->OFF on clr=1.
REQ-026 In EHOLD, cfg_en is ignored.
REQ-027 rx_en is registered and equals 1 only when the state is RUN, so it is 1 the cycle after the state enters RUN.
REQ-028 rx_chk is registered: it copies cfg_chk in OFF and holds its value in RUN and EHOLD.
REQ-029 The push event is the rising edge of rx_int, taken from a 1-cycle delayed copy; exactly one push occurs per rx_int high period.
REQ-030 A push is accepted only in RUN; the stored entry is {rx_err & rx_chk, rx_dat}.
REQ-031 rd_req while not empty pops the oldest entry; rd_dat, rd_perr and rd_vld appear the next cycle; rd_vld is high for 1 cycle.
REQ-032 rd_req while empty is ignored: rd_vld stays 0 and level is unchanged.
REQ-033 Push while full with no pop drops the byte and sets ovf; level stays DEPTH.
REQ-034 Push and pop in the same cycle when full both succeed and level stays DEPTH; ovf is not set.
REQ-035 Push and pop in the same cycle when empty: the push succeeds, the pop is ignored, and level becomes 1.
REQ-036 Read and write pointers wrap modulo DEPTH.
REQ-037 perr_cnt increments on each accepted push whose stored parity bit is 1; it saturates at 255.
REQ-038 irq = (level >= cfg_thr and cfg_thr != 0) or ovf or (state == EHOLD); irq is registered.
REQ-039 clr resets ovf and perr_cnt to 0; if a clr and a set occur in the same cycle, the set wins.
REQ-040 clr does not flush FIFO contents.
REQ-041 Leaving RUN does not flush the FIFO; entries stay readable in OFF and EHOLD.

Reset
REQ-042 While rst=1: state=OFF, rx_en=0, rx_chk=0, pointers=0, level=0, empty=1, full=0, ovf=0, perr_cnt=0, rd_vld=0, rd_dat=0, rd_perr=0, irq=0, and the rx_int delay register=0.
REQ-043 A reset during reception discards FIFO contents; the first push after release requires a new rx_int rising edge.

Verification
REQ-044 Scenario: cfg_en=1, three rx_int pulses each 4 cycles wide with data 0x41, 0x42, 0x43 -> level=3; three pops return 0x41, 0x42, 0x43 in order with rd_perr=0.
REQ-045 Scenario: 9 pushes with DEPTH=8 and no pops -> full=1, ovf=1, level=8; pops return the first 8 bytes; a clr pulse sets ovf=0.
REQ-046 Scenario: at level=8, push and rd_req in the same cycle -> level=8, ovf=0; the oldest byte is output and the new byte becomes the last entry.
REQ-047 Scenario: cfg_chk=1, cfg_hold=1, push with rx_err=1 and data 0x55 -> perr_cnt=1, state=EHOLD, rx_en=0 the next cycle, irq=1; the pop returns 0x55 with rd_perr=1; clr moves the state to OFF, then to RUN because cfg_en=1.
REQ-048 Scenario: cfg_thr=2 -> irq=0 at level 1 and irq=1 one cycle after level reaches 2; with cfg_thr=0 irq stays 0 at any level.
REQ-049 Scenario: rst asserted with level=5 mid-burst -> all outputs take their reset values asynchronously, and a rx_int already high at release causes no push.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: receiver enable/parity control, byte FIFO,
// sticky overflow and parity-error statistics, and a level interrupt.
module uart_rx_ctrl #(
    parameter int DEPTH = 8,
    parameter int LW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_en,
    input  logic          cfg_chk,
    input  logic          cfg_hold,
    input  logic [LW-1:0] cfg_thr,
    input  logic          clr,
    input  logic          rx_int,
    input  logic [7:0]    rx_dat,
    input  logic          rx_err,
    output logic          rx_en,
    output logic          rx_chk,
    input  logic          rd_req,
    output logic [7:0]    rd_dat,
    output logic          rd_perr,
    output logic          rd_vld,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level,
    output logic          ovf,
    output logic [7:0]    perr_cnt,
    output logic          irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        EHOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          int_d;
    logic          push_ev;
    logic          push;
    logic          pop;
    logic          wr;
    logic          drop;
    logic          perr_bit;
    logic          inc;
    logic          rx_en_nxt;
    logic          rx_chk_nxt;
    logic          irq_nxt;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Push/pop qualification; a push is only taken while receiving
    always_comb begin
        push_ev  = rx_int & ~int_d;
        push     = push_ev && (state == RUN);
        pop      = rd_req && !empty;
        wr       = push && (!full || pop);
        drop     = push && full && !pop;
        perr_bit = rx_err & rx_chk;
        inc      = wr && perr_bit;
    end

    // FIFO status decoded from the occupancy counter
    always_comb begin
        empty = (level == '0);
        full  = (level == FULL_LVL);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an error-hold push outranks a disable
    always_comb begin
        state_nxt = state;
        unique case (state)
            OFF: begin
                if (cfg_en) state_nxt = RUN;
            end
            RUN: begin
                if (push && rx_err && cfg_hold) state_nxt = EHOLD;
                else if (!cfg_en)               state_nxt = OFF;
            end
            EHOLD: begin
                if (clr) state_nxt = OFF;
            end
            default: state_nxt = OFF;
        endcase
    end

    // Output decode feeding the registered control outputs
    always_comb begin
        rx_en_nxt  = (state == RUN);
        rx_chk_nxt = (state == OFF) ? cfg_chk : rx_chk;
        irq_nxt    = ((level >= cfg_thr) && (cfg_thr != '0))
                     || ovf || (state == EHOLD);
    end

    // Registered control outputs and rx_int edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_en  <= 1'b0;
            rx_chk <= 1'b0;
            irq    <= 1'b0;
            int_d  <= 1'b0;
        end else begin
            rx_en  <= rx_en_nxt;
            rx_chk <= rx_chk_nxt;
            irq    <= irq_nxt;
            int_d  <= rx_int;
        end
    end

    // FIFO storage; contents need no reset since level gates reads
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= {perr_bit, rx_dat};
    end

    // Pointers, occupancy and read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            rd_vld  <= 1'b0;
            rd_dat  <= 8'h00;
            rd_perr <= 1'b0;
        end else begin
            rd_vld <= pop;
            if (pop) begin
                {rd_perr, rd_dat} <= mem[rptr];
                rptr              <= rptr + AW'(1);
            end
            if (wr) wptr <= wptr + AW'(1);
            if (wr && !pop)      level <= level + LW'(1);
            else if (pop && !wr) level <= level - LW'(1);
        end
    end

    // Sticky flags; a set in the same cycle as clr survives it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf      <= 1'b0;
            perr_cnt <= 8'h00;
        end else begin
            if (drop)     ovf <= 1'b1;
            else if (clr) ovf <= 1'b0;
            if (clr)                        perr_cnt <= {7'h00, inc};
            else if (inc && perr_cnt != 8'hff) perr_cnt <= perr_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_en = 0, cfg_chk = 0, cfg_hold = 0, clr = 0;
    logic [LW-1:0] cfg_thr = '0;
    logic          rx_int = 0, rx_err = 0, rd_req = 0;
    logic [7:0]    rx_dat = 8'h00;
    logic          rx_en, rx_chk, rd_perr, rd_vld, empty, full, ovf, irq;
    logic [7:0]    rd_dat, perr_cnt;
    logic [LW-1:0] level;

    int errors = 0;
    int checks = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_chk(cfg_chk),
        .cfg_hold(cfg_hold), .cfg_thr(cfg_thr), .clr(clr),
        .rx_int(rx_int), .rx_dat(rx_dat), .rx_err(rx_err),
        .rx_en(rx_en), .rx_chk(rx_chk), .rd_req(rd_req),
        .rd_dat(rd_dat), .rd_perr(rd_perr), .rd_vld(rd_vld),
        .empty(empty), .full(full), .level(level), .ovf(ovf),
        .perr_cnt(perr_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: mode 0=off, 1=receiving, 2=held on error
    int         m_mode = 0;
    bit         m_en = 0, m_chk = 0, m_prev = 0, m_ovf = 0;
    bit         m_vld = 0, m_pe = 0, m_irq = 0;
    int         m_pc = 0;
    logic [7:0] m_dat = 8'h00;
    bit   [8:0] q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_en = 0; m_chk = 0; m_prev = 0; m_ovf = 0;
            m_vld = 0; m_pe = 0; m_irq = 0; m_pc = 0; m_dat = 8'h00;
            q.delete();
        end else begin
            int lvl;
            bit ev, acc, pop, stored, drop, pb, inc;
            bit [8:0] e;
            lvl    = q.size();
            ev     = rx_int && !m_prev;
            m_prev = rx_int;
            acc    = ev && (m_mode == 1);
            pop    = rd_req && (lvl > 0);
            m_irq  = ((cfg_thr != 0) && (lvl >= int'(cfg_thr)))
                     || m_ovf || (m_mode == 2);
            pb     = rx_err && m_chk;
            m_vld  = pop;
            if (pop) begin
                e = q.pop_front();
                m_dat = e[7:0];
                m_pe  = e[8];
            end
            stored = 0;
            drop   = 0;
            if (acc) begin
                if (q.size() < DEPTH) begin
                    q.push_back({pb, rx_dat});
                    stored = 1;
                end else begin
                    drop = 1;
                end
            end
            if (drop)     m_ovf = 1;
            else if (clr) m_ovf = 0;
            inc = stored && pb;
            if (clr)                   m_pc = inc ? 1 : 0;
            else if (inc && m_pc < 255) m_pc++;
            m_en = (m_mode == 1);
            if (m_mode == 0) m_chk = cfg_chk;
            case (m_mode)
                0: if (cfg_en) m_mode = 1;
                1: if (acc && rx_err && cfg_hold) m_mode = 2;
                   else if (!cfg_en)             m_mode = 0;
                default: if (clr) m_mode = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("rx_en", rx_en, m_en);
            chk("rx_chk", rx_chk, m_chk);
            chk("level", level, q.size());
            chk("empty", empty, q.size() == 0);
            chk("full", full, q.size() == DEPTH);
            chk("ovf", ovf, m_ovf);
            chk("perr_cnt", perr_cnt, m_pc);
            chk("irq", irq, m_irq);
            chk("rd_vld", rd_vld, m_vld);
            if (m_vld) begin
                chk("rd_dat", rd_dat, m_dat);
                chk("rd_perr", rd_perr, m_pe);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(logic [7:0] d, bit e, int w, int gap);
        rx_dat = d; rx_err = e; rx_int = 1;
        cyc(w);
        rx_int = 0;
        cyc(gap);
    endtask

    task automatic pop_chk(string nm, logic [7:0] d, bit p);
        rd_req = 1;
        cyc(1);
        rd_req = 0;
        chk({nm, "_vld"}, rd_vld, 1);
        chk({nm, "_dat"}, rd_dat, d);
        chk({nm, "_perr"}, rd_perr, p);
    endtask

    task automatic reset_vals(string nm);
        chk({nm, "_rx_en"}, rx_en, 0);
        chk({nm, "_rx_chk"}, rx_chk, 0);
        chk({nm, "_level"}, level, 0);
        chk({nm, "_empty"}, empty, 1);
        chk({nm, "_full"}, full, 0);
        chk({nm, "_ovf"}, ovf, 0);
        chk({nm, "_perr_cnt"}, perr_cnt, 0);
        chk({nm, "_rd_vld"}, rd_vld, 0);
        chk({nm, "_rd_dat"}, rd_dat, 0);
        chk({nm, "_rd_perr"}, rd_perr, 0);
        chk({nm, "_irq"}, irq, 0);
    endtask

    initial begin
        int wleft;
        cyc(2);
        reset_vals("rst");
        rst = 0;
        cyc(1);

        // In-order reception of three bytes
        cfg_en = 1;
        cyc(2);
        pulse(8'h41, 0, 4, 2);
        pulse(8'h42, 0, 4, 2);
        pulse(8'h43, 0, 4, 2);
        chk("s1_level", level, 3);
        pop_chk("s1_p0", 8'h41, 0);
        pop_chk("s1_p1", 8'h42, 0);
        pop_chk("s1_p2", 8'h43, 0);

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) pulse(8'h10 + 8'(i), 0, 2, 1);
        chk("s2_full", full, 1);
        chk("s2_ovf", ovf, 1);
        chk("s2_level", level, 8);
        for (int i = 0; i < 8; i++) pop_chk("s2_pop", 8'h10 + 8'(i), 0);
        chk("s2_empty", empty, 1);
        clr = 1;
        cyc(1);
        clr = 0;
        chk("s2_ovf_clr", ovf, 0);

        // Simultaneous push and pop while full
        for (int i = 0; i < 8; i++) pulse(8'h20 + 8'(i), 0, 2, 1);
        rx_dat = 8'h99; rx_int = 1; rd_req = 1;
        cyc(1);
        rd_req = 0;
        chk("s3_level", level, 8);
        chk("s3_ovf", ovf, 0);
        chk("s3_vld", rd_vld, 1);
        chk("s3_dat", rd_dat, 8'h20);
        cyc(2);
        rx_int = 0;
        for (int i = 1; i < 8; i++) pop_chk("s3_pop", 8'h20 + 8'(i), 0);
        pop_chk("s3_last", 8'h99, 0);
        chk("s3_empty", level, 0);

        // Parity error with hold
        cfg_en = 0;
        cyc(2);
        cfg_chk = 1; cfg_hold = 1;
        cyc(1);
        cfg_en = 1;
        cyc(2);
        chk("s4_rx_chk", rx_chk, 1);
        chk("s4_rx_en", rx_en, 1);
        rx_dat = 8'h55; rx_err = 1; rx_int = 1;
        cyc(1);
        chk("s4_perr_cnt", perr_cnt, 1);
        cyc(1);
        chk("s4_rx_en_off", rx_en, 0);
        chk("s4_irq", irq, 1);
        rx_int = 0; rx_err = 0;
        pop_chk("s4_pop", 8'h55, 1);
        clr = 1;
        cyc(1);
        clr = 0;
        chk("s4_perr_clr", perr_cnt, 0);
        cyc(2);
        chk("s4_rx_en_back", rx_en, 1);
        cfg_hold = 0;

        // Threshold interrupt
        cfg_thr = 4'd2;
        pulse(8'h61, 0, 2, 2);
        chk("s5_lvl1_irq", irq, 0);
        rx_dat = 8'h62; rx_int = 1;
        cyc(1);
        chk("s5_level", level, 2);
        chk("s5_irq_lag", irq, 0);
        cyc(1);
        chk("s5_irq", irq, 1);
        rx_int = 0;
        cfg_thr = 4'd0;
        cyc(2);
        chk("s5_thr0", irq, 0);
        pop_chk("s5_p0", 8'h61, 0);
        pop_chk("s5_p1", 8'h62, 0);

        // Random traffic against the model
        wleft = 0;
        for (int c = 0; c < 4000; c++) begin
            clr = ($urandom_range(0, 24) == 0);
            if (rx_int) begin
                if (wleft <= 1) rx_int = 0;
                else wleft--;
            end else if ($urandom_range(0, 3) == 0) begin
                rx_int = 1;
                wleft  = $urandom_range(1, 4);
                rx_dat = 8'($urandom);
                rx_err = ($urandom_range(0, 3) == 0);
            end
            if (c < 2000) rd_req = ($urandom_range(0, 7) == 0);
            else          rd_req = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) cfg_en = ~cfg_en;
            if ($urandom_range(0, 29) == 0) cfg_chk = ~cfg_chk;
            if ($urandom_range(0, 39) == 0) cfg_hold = ~cfg_hold;
            if ($urandom_range(0, 99) == 0) cfg_thr = LW'($urandom_range(0, DEPTH));
            cyc(1);
        end
        rx_int = 0; rd_req = 0; clr = 0; cfg_hold = 0; cfg_thr = '0;
        cyc(2);

        // Asynchronous reset mid-burst
        rst = 1;
        cyc(1);
        rst = 0;
        cfg_en = 1;
        cyc(2);
        for (int i = 0; i < 5; i++) pulse(8'h70 + 8'(i), 0, 2, 1);
        chk("s6_level5", level, 5);
        rx_dat = 8'h7f; rx_int = 1;
        cyc(1);
        #3;
        rst = 1;
        #1;
        reset_vals("arst");
        cyc(2);
        rst = 0;
        cyc(4);
        chk("s6_no_push", level, 0);
        rx_int = 0;
        cyc(1);
        pulse(8'h80, 0, 2, 2);
        chk("s6_push_after", level, 1);
        pop_chk("s6_pop", 8'h80, 0);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
